// File: rtl/config_pkg.sv
// Core configuration subset consumed by the WorldGuard tagging stage.
// Field names match the CVA6 config struct so the block drops in unchanged.
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned AxiAddrWidth;
    int unsigned AxiIdWidth;
    int unsigned WgNWorlds;
    bit          WgSMWGEn;
    bit          WgSSWGEn;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{
    XLEN:         64,
    AxiAddrWidth: 64,
    AxiIdWidth:   4,
    WgNWorlds:    128,
    WgSMWGEn:     1'b1,
    WgSSWGEn:     1'b1
  };

endpackage

// File: rtl/wg_pkg.sv
// WorldGuard shared definitions: CSR addresses, privilege codes,
// tagger FSM states and the world-ID type.
package wg_pkg;

  localparam logic [11:0] CSR_MLWID     = 12'h390;
  localparam logic [11:0] CSR_SLWID     = 12'h190;
  localparam logic [11:0] CSR_MWIDDELEG = 12'h748;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam int unsigned WG_WID_W = 7;

  typedef logic [WG_WID_W-1:0] wid_t;

  typedef enum logic {
    ST_RUN,
    ST_DRAIN
  } wg_state_e;

endpackage

// File: rtl/wg_csr.sv
// WorldGuard CSR storage (mlwid, slwid, mwiddeleg) with WARL
// legalisation and effective world-ID selection.
module wg_csr
  import wg_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg =
    config_pkg::cva6_cfg_empty,
  parameter int unsigned WidWidth =
    $clog2(CVA6Cfg.WgNWorlds)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [WidWidth-1:0]     mwid_i,
  input  logic [1:0]              priv_lvl_i,
  input  logic                    v_i,
  input  logic                    csr_we_i,
  input  logic [11:0]             csr_addr_i,
  input  logic [CVA6Cfg.XLEN-1:0] csr_wdata_i,
  output logic [CVA6Cfg.XLEN-1:0] csr_rdata_o,
  output logic                    csr_hit_o,
  output logic [WidWidth-1:0]     wid_next_o
);

  localparam int unsigned DelegW =
    (CVA6Cfg.WgNWorlds < CVA6Cfg.XLEN) ?
    CVA6Cfg.WgNWorlds : CVA6Cfg.XLEN;

  logic [WidWidth-1:0] mlwid_q;
  logic [WidWidth-1:0] slwid_q;
  logic [DelegW-1:0]   deleg_q;

  logic                is_m;
  logic                hit_ml;
  logic                hit_sl;
  logic                hit_dl;
  logic                deleg_ok;
  logic [WidWidth-1:0] req_idx;
  logic                unused_ok;

  // VS/VU resolve exactly like S/U, so v_i carries no extra selection.
  assign unused_ok = ^{v_i, csr_wdata_i};

  assign is_m    = (priv_lvl_i == PRIV_M);
  assign hit_ml  = CVA6Cfg.WgSMWGEn &&
                   (csr_addr_i == CSR_MLWID);
  assign hit_dl  = CVA6Cfg.WgSMWGEn &&
                   (csr_addr_i == CSR_MWIDDELEG);
  assign hit_sl  = CVA6Cfg.WgSSWGEn &&
                   (csr_addr_i == CSR_SLWID);
  assign req_idx = csr_wdata_i[WidWidth-1:0];

  // Worlds beyond the delegation mask width are never delegated.
  always_comb begin
    deleg_ok = 1'b0;
    for (int i = 0; i < int'(DelegW); i++) begin
      if (req_idx == WidWidth'(i)) deleg_ok = deleg_q[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mlwid_q <= '0;
      slwid_q <= '0;
      deleg_q <= '0;
    end else if (csr_we_i) begin
      if (is_m && hit_ml) mlwid_q <= req_idx;
      if (is_m && hit_dl) deleg_q <= csr_wdata_i[DelegW-1:0];
      if (hit_sl && deleg_ok) slwid_q <= req_idx;
    end
  end

  assign csr_hit_o = hit_ml || hit_sl || hit_dl;

  always_comb begin
    csr_rdata_o = '0;
    unique case (1'b1)
      hit_ml:  csr_rdata_o[WidWidth-1:0] = mlwid_q;
      hit_sl:  csr_rdata_o[WidWidth-1:0] = slwid_q;
      hit_dl:  csr_rdata_o[DelegW-1:0]   = deleg_q;
      default: csr_rdata_o = '0;
    endcase
  end

  always_comb begin
    wid_next_o = slwid_q;
    if (is_m)                wid_next_o = mwid_i;
    else if (deleg_q == '0)  wid_next_o = mlwid_q;
  end

endmodule

// File: rtl/wg_wid_tagger.sv
// WorldGuard request tagger: stamps each request with the applied WID
// and drains all in-flight traffic before switching worlds.
module wg_wid_tagger
  import wg_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg =
    config_pkg::cva6_cfg_empty,
  parameter int unsigned MaxOutstanding = 7,
  parameter int unsigned WidWidth =
    $clog2(CVA6Cfg.WgNWorlds)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [WidWidth-1:0]             mwid_i,
  input  logic [1:0]                      priv_lvl_i,
  input  logic                            v_i,
  input  logic                            csr_we_i,
  input  logic [11:0]                     csr_addr_i,
  input  logic [CVA6Cfg.XLEN-1:0]         csr_wdata_i,
  output logic [CVA6Cfg.XLEN-1:0]         csr_rdata_o,
  output logic                            csr_hit_o,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [CVA6Cfg.AxiAddrWidth-1:0] req_addr_i,
  input  logic                            req_we_i,
  input  logic [CVA6Cfg.AxiIdWidth-1:0]   req_id_i,
  output logic                            req_valid_o,
  input  logic                            req_ready_i,
  output logic [CVA6Cfg.AxiAddrWidth-1:0] req_addr_o,
  output logic                            req_we_o,
  output logic [CVA6Cfg.AxiIdWidth-1:0]   req_id_o,
  output logic [WidWidth-1:0]             req_wid_o,
  input  logic                            rsp_done_i,
  output logic [WidWidth-1:0]             wid_o,
  output logic                            busy_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  wg_state_e           state_q;
  wg_state_e           state_d;
  logic [CntW-1:0]     cnt_q;
  logic [WidWidth-1:0] wid_q;
  logic [WidWidth-1:0] wid_next;
  logic                wid_load;
  logic                init_q;
  logic                ready;
  logic                in_hs;
  logic                out_hs;
  logic                inc;
  logic                dec;

  wg_csr #(
    .CVA6Cfg  (CVA6Cfg),
    .WidWidth (WidWidth)
  ) i_csr (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .mwid_i      (mwid_i),
    .priv_lvl_i  (priv_lvl_i),
    .v_i         (v_i),
    .csr_we_i    (csr_we_i),
    .csr_addr_i  (csr_addr_i),
    .csr_wdata_i (csr_wdata_i),
    .csr_rdata_o (csr_rdata_o),
    .csr_hit_o   (csr_hit_o),
    .wid_next_o  (wid_next)
  );

  // Until the first post-reset edge has captured mwid_i the applied
  // WID is not meaningful, so nothing is accepted or compared.
  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    wid_load = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (init_q) begin
          if (wid_next != wid_q) begin
            state_d = ST_DRAIN;
          end else begin
            ready = (cnt_q < CntMax) &&
                    (!req_valid_o || req_ready_i);
          end
        end
      end
      ST_DRAIN: begin
        if (!req_valid_o && cnt_q == '0) begin
          wid_load = 1'b1;
          state_d  = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign req_ready_o = ready;
  assign in_hs  = req_valid_i && ready;
  assign out_hs = req_valid_o && req_ready_i;
  assign inc    = out_hs;
  assign dec    = rsp_done_i && (cnt_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      init_q  <= 1'b0;
      wid_q   <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      if (!init_q)       wid_q <= mwid_i;
      else if (wid_load) wid_q <= wid_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (inc && !dec) begin
      if (cnt_q != CntMax) cnt_q <= cnt_q + 1'b1;
    end else if (dec && !inc) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_valid_o <= 1'b0;
      req_addr_o  <= '0;
      req_we_o    <= 1'b0;
      req_id_o    <= '0;
      req_wid_o   <= '0;
    end else if (in_hs) begin
      req_valid_o <= 1'b1;
      req_addr_o  <= req_addr_i;
      req_we_o    <= req_we_i;
      req_id_o    <= req_id_i;
      req_wid_o   <= wid_q;
    end else if (out_hs) begin
      req_valid_o <= 1'b0;
    end
  end

  assign wid_o  = wid_q;
  assign busy_o = (state_q == ST_DRAIN) || (cnt_q != '0);

endmodule

// File: tb/tb_wg_wid_tagger.sv
// Directed bench for wg_wid_tagger: CSR vector table plus
// hand-written drain, backpressure, counter and reset sequences.
module tb_wg_wid_tagger;
  import wg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [6:0]  mwid = 7'd5;
  logic [1:0]  priv = PRIV_M;
  logic        v = 1'b0;
  logic        csr_we = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [63:0] csr_wdata = '0;
  logic [63:0] csr_rdata;
  logic        csr_hit;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_addr = '0;
  logic        in_we = 1'b0;
  logic [3:0]  in_id = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_addr;
  logic        out_we;
  logic [3:0]  out_id;
  logic [6:0]  out_wid;
  logic        rsp_done = 1'b0;
  logic [6:0]  wid;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wg_wid_tagger dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .mwid_i      (mwid),
    .priv_lvl_i  (priv),
    .v_i         (v),
    .csr_we_i    (csr_we),
    .csr_addr_i  (csr_addr),
    .csr_wdata_i (csr_wdata),
    .csr_rdata_o (csr_rdata),
    .csr_hit_o   (csr_hit),
    .req_valid_i (in_valid),
    .req_ready_o (in_ready),
    .req_addr_i  (in_addr),
    .req_we_i    (in_we),
    .req_id_i    (in_id),
    .req_valid_o (out_valid),
    .req_ready_i (out_ready),
    .req_addr_o  (out_addr),
    .req_we_o    (out_we),
    .req_id_o    (out_id),
    .req_wid_o   (out_wid),
    .rsp_done_i  (rsp_done),
    .wid_o       (wid),
    .busy_o      (busy)
  );

  typedef struct {
    string       name;
    logic [1:0]  priv;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [11:0] raddr;
    logic [63:0] exp_rdata;
    logic        exp_hit;
  } csr_vec_t;

  csr_vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input int i);
    priv      = vecs[i].priv;
    csr_addr  = vecs[i].addr;
    csr_wdata = vecs[i].wdata;
    csr_we    = 1'b1;
    tick();
    csr_we   = 1'b0;
    csr_addr = vecs[i].raddr;
    #1;
    check({vecs[i].name, "_rd"}, csr_rdata, vecs[i].exp_rdata);
    check({vecs[i].name, "_hit"}, 64'(csr_hit),
          64'(vecs[i].exp_hit));
  endtask

  task automatic wait_wid(input string name, input logic [6:0] exp);
    for (int i = 0; i < 20 && (wid !== exp || busy); i++) tick();
    check(name, 64'(wid), 64'(exp));
  endtask

  task automatic one_req(input string name,
                         input logic [63:0] a,
                         input logic [6:0] exp_wid);
    in_addr   = a;
    in_id     = 4'd2;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check({name, "_wid"}, 64'(out_wid), 64'(exp_wid));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    rsp_done  = 1'b1;
    tick();
    rsp_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{"mlwid_wr", PRIV_M, CSR_MLWID, 64'd9,
                 CSR_MLWID, 64'd9, 1'b1};
    vecs[1]  = '{"mlwid_warl", PRIV_M, CSR_MLWID, 64'h1FF,
                 CSR_MLWID, 64'h7F, 1'b1};
    vecs[2]  = '{"mlwid_s_drop", PRIV_S, CSR_MLWID, 64'd3,
                 CSR_MLWID, 64'h7F, 1'b1};
    vecs[3]  = '{"mlwid_restore", PRIV_M, CSR_MLWID, 64'd9,
                 CSR_MLWID, 64'd9, 1'b1};
    vecs[4]  = '{"slwid_nodeleg", PRIV_M, CSR_SLWID, 64'd4,
                 CSR_SLWID, 64'd0, 1'b1};
    vecs[5]  = '{"deleg_s_drop", PRIV_S, CSR_MWIDDELEG, 64'h10,
                 CSR_MWIDDELEG, 64'd0, 1'b1};
    vecs[6]  = '{"unmapped", PRIV_M, 12'h123, 64'd5,
                 12'h123, 64'd0, 1'b0};
    vecs[7]  = '{"deleg_wr", PRIV_M, CSR_MWIDDELEG, 64'h10,
                 CSR_MWIDDELEG, 64'h10, 1'b1};
    vecs[8]  = '{"slwid_ok", PRIV_M, CSR_SLWID, 64'd4,
                 CSR_SLWID, 64'd4, 1'b1};
    vecs[9]  = '{"slwid_rej", PRIV_S, CSR_SLWID, 64'd3,
                 CSR_SLWID, 64'd4, 1'b1};
    vecs[10] = '{"slwid_oob", PRIV_M, CSR_SLWID, 64'h45,
                 CSR_SLWID, 64'd4, 1'b1};
    vecs[11] = '{"deleg_full", PRIV_M, CSR_MWIDDELEG,
                 64'hFFFF_0000_0000_0010, CSR_MWIDDELEG,
                 64'hFFFF_0000_0000_0010, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wid", 64'(wid), 64'd0);
    csr_addr = CSR_MLWID;
    #1;
    check("rst_mlwid", csr_rdata, 64'd0);
    rst_ni = 1'b1;
    tick();
    check("init_wid", 64'(wid), 64'd5);
    check("init_ready", 64'(in_ready), 64'd1);

    // Single M-mode request
    in_addr   = 64'h1000;
    in_id     = 4'd3;
    in_we     = 1'b1;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    in_we    = 1'b0;
    check("f1_valid", 64'(out_valid), 64'd1);
    check("f1_wid", 64'(out_wid), 64'd5);
    check("f1_addr", out_addr, 64'h1000);
    check("f1_id", 64'(out_id), 64'd3);
    check("f1_we", 64'(out_we), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("f1_busy", 64'(busy), 64'd1);
    check("f1_empty", 64'(out_valid), 64'd0);
    rsp_done = 1'b1;
    tick();
    rsp_done = 1'b0;
    check("f1_idle", 64'(busy), 64'd0);

    for (int i = 0; i < 7; i++) apply_vec(i);
    priv = PRIV_M;
    wait_wid("m_back_a", 7'd5);

    // S mode, no delegation: mlwid applies after one DRAIN cycle
    priv = PRIV_S;
    #1;
    check("f2_ready_drop", 64'(in_ready), 64'd0);
    tick();
    check("f2_drain", 64'(busy), 64'd1);
    check("f2_old_wid", 64'(wid), 64'd5);
    tick();
    check("f2_new_wid", 64'(wid), 64'd9);
    check("f2_ready", 64'(in_ready), 64'd1);
    one_req("f2", 64'h2000, 7'd9);

    priv = PRIV_M;
    wait_wid("m_back_b", 7'd5);
    for (int i = 7; i < 12; i++) apply_vec(i);
    priv = PRIV_S;
    wait_wid("f3_slwid", 7'd4);
    one_req("f3", 64'h3000, 7'd4);

    // Outstanding limit
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_id    = 4'(k);
      in_valid = 1'b1;
      #1;
      check("f4_accept", 64'(in_ready), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    in_id    = 4'd9;
    #1;
    check("f4_full", 64'(in_ready), 64'd0);
    tick();
    check("f4_still_full", 64'(in_ready), 64'd0);
    rsp_done = 1'b1;
    tick();
    rsp_done = 1'b0;
    #1;
    check("f4_reopen", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("f4_8th_valid", 64'(out_valid), 64'd1);
    check("f4_8th_id", 64'(out_id), 64'd9);
    tick();
    rsp_done = 1'b1;
    repeat (7) tick();
    rsp_done = 1'b0;
    check("f4_drained", 64'(busy), 64'd0);

    // WID change with traffic held by backpressure
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      in_addr = 64'h5000 + 64'(k);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    priv      = PRIV_M;
    in_valid  = 1'b1;
    in_addr   = 64'h6000;
    #1;
    check("f5_block", 64'(in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("f5_hold_valid", 64'(out_valid), 64'd1);
      check("f5_hold_addr", out_addr, 64'h5003);
      check("f5_hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("f5_released", 64'(out_valid), 64'd0);
    rsp_done = 1'b1;
    repeat (2) tick();
    check("f5_mid_wid", 64'(wid), 64'd4);
    check("f5_mid_ready", 64'(in_ready), 64'd0);
    tick();
    rsp_done = 1'b0;
    in_valid = 1'b0;
    check("f5_wid_hold", 64'(wid), 64'd4);
    tick();
    check("f5_wid_new", 64'(wid), 64'd5);

    // Simultaneous handshake and response at count 2
    out_ready = 1'b1;
    in_valid  = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    tick();
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rsp_done  = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("f6_cnt1", 64'(busy), 64'd1);
    tick();
    rsp_done = 1'b0;
    check("f6_cnt0", 64'(busy), 64'd0);
    rsp_done = 1'b1;
    tick();
    rsp_done  = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("f6_zero_ign", 64'(busy), 64'd1);
    rsp_done = 1'b1;
    tick();
    rsp_done = 1'b0;
    check("f6_idle", 64'(busy), 64'd0);

    // Reset mid-burst
    out_ready = 1'b1;
    in_valid  = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    rst_ni    = 1'b0;
    #1;
    check("r_valid", 64'(out_valid), 64'd0);
    check("r_busy", 64'(busy), 64'd0);
    check("r_wid", 64'(wid), 64'd0);
    rst_ni = 1'b1;
    tick();
    check("r_wid_init", 64'(wid), 64'd5);
    check("r_valid_after", 64'(out_valid), 64'd0);
    check("r_busy_after", 64'(busy), 64'd0);
    csr_addr = CSR_MLWID;
    #1;
    check("r_mlwid", csr_rdata, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
